// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with a per-register pending-write scoreboard.
// Ports:
//   clk, reset_n         clock; synchronous active-low reset
//   rd_addr/rd_data      RD_PORTS combinational read ports (packed, port p at [p*AW +: AW] / [p*WD_SIZE +: WD_SIZE])
//   rd_busy              scoreboard bit of each read port's register
//   wr_en/wr_addr/wr_data WR_PORTS write ports, higher index wins on collision
//   alloc_en/alloc_addr  mark a register pending when an instruction issues
//   busy_vec             full scoreboard, bit i = register i pending
// Optional feature: define REGFILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
// Register 0 is hardwired to zero and is never pending.
module regfile_mp #(
   parameter int REG_NUM  = 32,
   parameter int WD_SIZE  = 32,
   parameter int RD_PORTS = 2,
   parameter int WR_PORTS = 2,
   localparam int AW      = $clog2(REG_NUM)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [RD_PORTS*AW-1:0]       rd_addr,
   output logic [RD_PORTS*WD_SIZE-1:0]  rd_data,
   output logic [RD_PORTS-1:0]          rd_busy,
   input  logic [WR_PORTS-1:0]          wr_en,
   input  logic [WR_PORTS*AW-1:0]       wr_addr,
   input  logic [WR_PORTS*WD_SIZE-1:0]  wr_data,
   input  logic                         alloc_en,
   input  logic [AW-1:0]                alloc_addr,
   output logic [REG_NUM-1:0]           busy_vec
);
   logic [WD_SIZE-1:0] regs_q [REG_NUM];
   logic [WD_SIZE-1:0] regs_d [REG_NUM];
   logic [REG_NUM-1:0] busy_q, busy_d;

   // Writes applied in ascending port order so the highest port wins; alloc applied last so a new producer wins over a completing one.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (!reset_n) begin
         regs_d = '{default: '0};
         busy_d = '0;
      end else begin
         for (int w = 0; w < WR_PORTS; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] != '0) begin
               regs_d[wr_addr[w*AW +: AW]] = wr_data[w*WD_SIZE +: WD_SIZE];
               busy_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
         end
         if (alloc_en && alloc_addr != '0) busy_d[alloc_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      regs_q <= regs_d;
      busy_q <= busy_d;
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int p = 0; p < RD_PORTS; p++) begin
         if (rd_addr[p*AW +: AW] != '0) begin
            rd_data[p*WD_SIZE +: WD_SIZE] = regs_q[rd_addr[p*AW +: AW]];
            rd_busy[p] = busy_q[rd_addr[p*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
            for (int w = 0; w < WR_PORTS; w++) begin
               if (wr_en[w] && wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW]) begin
                  rd_data[p*WD_SIZE +: WD_SIZE] = wr_data[w*WD_SIZE +: WD_SIZE];
                  rd_busy[p] = alloc_en && alloc_addr == rd_addr[p*AW +: AW];
               end
            end
`endif
         end
      end
   end

   assign busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against an array-based reference model.
module tb_regfile_mp;
   localparam int N = 32, W = 32, RP = 2, WP = 2, AW = 5;
`ifdef REGFILE_MP_BYPASS_EN
   localparam logic [W-1:0] X5_SAME = 32'hDEADBEEF;
`else
   localparam logic [W-1:0] X5_SAME = 32'h0;
`endif
   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [RP*AW-1:0] rd_addr = '0;
   logic [RP*W-1:0]  rd_data;
   logic [RP-1:0]    rd_busy;
   logic [WP-1:0]    wr_en = '0;
   logic [WP*AW-1:0] wr_addr = '0;
   logic [WP*W-1:0]  wr_data = '0;
   logic             alloc_en = 1'b0;
   logic [AW-1:0]    alloc_addr = '0;
   logic [N-1:0]     busy_vec;
   logic [W-1:0]     m_regs [N];
   logic [N-1:0]     m_busy;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] exp_data(input int p);
      logic [AW-1:0] a = rd_addr[p*AW +: AW];
      logic [W-1:0] v = (a == 0) ? '0 : m_regs[a];
`ifdef REGFILE_MP_BYPASS_EN
      for (int w = 0; w < WP; w++)
         if (a != 0 && wr_en[w] && wr_addr[w*AW +: AW] == a) v = wr_data[w*W +: W];
`endif
      return v;
   endfunction

   function automatic logic exp_busy(input int p);
      logic [AW-1:0] a = rd_addr[p*AW +: AW];
      logic v = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_MP_BYPASS_EN
      for (int w = 0; w < WP; w++)
         if (a != 0 && wr_en[w] && wr_addr[w*AW +: AW] == a) v = alloc_en && alloc_addr == a;
`endif
      return v;
   endfunction

   function automatic logic [AW-1:0] ra();
      return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, N-1)) : AW'($urandom_range(0, 7));
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) m_regs[i] = '0;
      m_busy = '0;
   endtask

   task automatic tick();
      #1;
      for (int p = 0; p < RP; p++) begin
         check($sformatf("rd_data%0d", p), 64'(rd_data[p*W +: W]), 64'(exp_data(p)));
         check($sformatf("rd_busy%0d", p), 64'(rd_busy[p]), 64'(exp_busy(p)));
      end
      check("busy_vec", 64'(busy_vec), 64'(m_busy));
      @(posedge clk);
      if (!reset_n) model_clear();
      else begin
         for (int w = 0; w < WP; w++)
            if (wr_en[w] && wr_addr[w*AW +: AW] != 0) begin
               m_regs[wr_addr[w*AW +: AW]] = wr_data[w*W +: W];
               m_busy[wr_addr[w*AW +: AW]] = 1'b0;
            end
         if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      reset_n = 1'b1;
      wr_en = '0;
      alloc_en = 1'b0;
   endtask

   initial begin
      wr_en = 2'b11;
      wr_addr = {5'd4, 5'd6};
      wr_data = {32'h1234, 32'h5678};
      alloc_en = 1'b1;
      alloc_addr = 5'd4;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_clear();
      idle();
      for (int i = 0; i < N; i++) begin
         rd_addr = {AW'(i), AW'(i)};
         tick();
      end
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF}; rd_addr = {5'd5, 5'd5};
      #1 check("x5_same_cycle", 64'(rd_data[W-1:0]), 64'(X5_SAME));
      tick();
      idle();
      #1 check("x5_next_cycle", 64'(rd_data[W-1:0]), 64'h0000_0000_DEAD_BEEF);
      tick();
      wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11}; rd_addr = {5'd7, 5'd7};
      tick();
      idle();
      #1 check("x7_port1_wins", 64'(rd_data[W-1:0]), 64'h22);
      tick();
      wr_en = 2'b01; wr_addr = '0; wr_data = {32'h0, 32'hFFFFFFFF}; alloc_en = 1'b1; alloc_addr = 5'd0; rd_addr = '0;
      tick();
      idle();
      #1 check("x0_data", 64'(rd_data), 64'h0);
      check("x0_busy", 64'(busy_vec[0]), 64'h0);
      tick();
      alloc_en = 1'b1; alloc_addr = 5'd3; rd_addr = {5'd3, 5'd3};
      tick();
      idle();
      #1 check("x3_alloc", 64'(busy_vec[3]), 64'h1);
      alloc_en = 1'b1; alloc_addr = 5'd3; wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h33};
      tick();
      idle();
      #1 check("x3_alloc_wins", 64'(busy_vec[3]), 64'h1);
      wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h44, 32'h0};
      tick();
      idle();
      #1 check("x3_cleared", 64'(busy_vec[3]), 64'h0);
      alloc_en = 1'b1; alloc_addr = 5'd9; rd_addr = {5'd9, 5'd9};
      tick();
      alloc_en = 1'b1; alloc_addr = 5'd9; wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h55}; reset_n = 1'b0;
      tick();
      idle();
      #1 check("x9_reset_data", 64'(rd_data[W-1:0]), 64'h0);
      check("x9_reset_busy", 64'(busy_vec), 64'h0);
      tick();
      repeat (400) begin
         reset_n = ($urandom_range(0, 24) != 0);
         wr_en = WP'($urandom);
         wr_addr = {ra(), ra()};
         wr_data = {$urandom, $urandom};
         alloc_en = 1'($urandom);
         alloc_addr = ra();
         rd_addr = {ra(), ra()};
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, number of architectural registers (power of two, >=2).
REQ-002 SHALL have parameter WD_SIZE, default 32, register width in bits.
REQ-003 SHALL have parameter RD_PORTS, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter WR_PORTS, default 2, number of write ports (1..2); AW = $clog2(REG_NUM).
REQ-005 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-006 SHALL have port: reset_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port: rd_addr  input  RD_PORTS*AW  read index, port p at bits [p*AW +: AW].
REQ-008 SHALL have port: rd_data  output  RD_PORTS*WD_SIZE  read data, port p at bits [p*WD_SIZE +: WD_SIZE].
REQ-009 SHALL have port: rd_busy  output  RD_PORTS  read register has a pending write (scoreboard bit set).
REQ-010 SHALL have port: wr_en  input  WR_PORTS  per-port write enable.
REQ-011 SHALL have port: wr_addr  input  WR_PORTS*AW  write index per port.
REQ-012 SHALL have port: wr_data  input  WR_PORTS*WD_SIZE  write data per port.
REQ-013 SHALL have port: alloc_en  input  1  mark alloc_addr pending (instruction issued).
REQ-014 SHALL have port: alloc_addr  input  AW  register to mark pending.
REQ-015 SHALL have port: busy_vec  output  REG_NUM  current scoreboard, bit i = register i pending.

Function
REQ-016 SHALL read combinationally: rd_data[p] = registers[rd_addr[p]], rd_busy[p] = busy_vec[rd_addr[p]].
REQ-017 SHALL write on rising clk edge: for each w with wr_en[w]=1 and wr_addr[w]!=0, registers[wr_addr[w]] <= wr_data[w].
REQ-018 SHALL, when two enabled write ports target the same non-zero address in one cycle, store the data of the higher-indexed port.
REQ-019 SHALL treat register 0 as hardwired: writes ignored, reads return 0, busy bit always 0, alloc to 0 ignored.
REQ-020 SHALL set busy bit alloc_addr on the rising edge when alloc_en=1 and alloc_addr!=0.
REQ-021 SHALL clear busy bit r on the rising edge when any enabled write port targets r.
REQ-022 SHALL, when alloc and a clearing write target the same register in one cycle, leave the bit set (alloc wins; new producer outstanding).
REQ-023 SHALL provide 1-cycle write-to-read latency without bypass: a read in the write cycle returns the old value.
REQ-024 SHALL ignore writes to non-pending registers for scoreboard purposes (data still written, busy stays 0).
REQ-025 SHALL not mutate any state while reset_n=0, regardless of wr_en/alloc_en.

Reset
REQ-026 SHALL, on a rising clk edge with reset_n=0, clear all registers to 0 and all busy bits to 0.
REQ-027 SHALL present rd_data=0, rd_busy=0, busy_vec=0 in the cycle after reset, for all addresses.
REQ-028 SHALL discard writes and allocs coincident with a reset edge, including mid-operation pending registers.

Configuration
REQ-029 SHALL, with macro REGFILE_MP_BYPASS_EN defined, forward same-cycle write data: if an enabled write port (highest index wins) targets rd_addr[p]!=0, rd_data[p]=that wr_data and rd_busy[p]=0 unless alloc_en targets the same register.
REQ-030 SHALL, without REGFILE_MP_BYPASS_EN, return only stored register state per REQ-016/REQ-023 with no combinational path from wr_* to rd_*.

Verification
REQ-031 SHALL cover: reset, then read all 32 addresses -> rd_data=0, busy_vec=0.
REQ-032 SHALL cover: wr_en=01, wr_addr[0]=5, data 0xDEADBEEF; read x5 same cycle -> old value 0 (bypass off) / 0xDEADBEEF (bypass on); next cycle -> 0xDEADBEEF.
REQ-033 SHALL cover: both ports write x7, port0=0x11, port1=0x22 -> x7=0x22 next cycle.
REQ-034 SHALL cover: write x0=0xFFFFFFFF and alloc x0 -> rd_data 0, busy_vec[0]=0.
REQ-035 SHALL cover: alloc x3 -> busy_vec[3]=1; next cycle alloc x3 plus write x3 -> busy_vec[3]=1; next cycle write x3 only -> busy_vec[3]=0.
REQ-036 SHALL cover: alloc x9, write x9=0x55, assert reset_n=0 same edge -> x9=0, busy_vec=0.
